// File: rtl/counter_pkg.sv
// Shared FSM encoding and seven-segment direction glyphs for the counter sequencer.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Active-low segments, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_UP = 7'b1000001;
  localparam logic [6:0] SEG_DN = 7'b0100001;

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit synchronous up/down counter with clear; updates on the edge where en is high.
// No latency beyond the register and no backpressure; clear has priority over enable.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop/pause sequencer stepping a counter every PRESCALE clocks; outputs registered, no backpressure.
// AUTO_REVERSE_EN selects ping-pong counting that bounces at 0 and 2^WIDTH-1 instead of wrapping.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_sw,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             wrap,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam logic [7:0]       PS_TERM = 8'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t     state;
  logic [7:0] presc;
  logic       go;
  logic       step;
  logic       clr;
  logic       core_up;
  logic       step_wrap;
  logic       dir_nxt;

  assign go   = start && !stop;
  // A stop on the terminal prescaler cycle drops that step.
  assign step = (state == RUN) && !stop && (presc == PS_TERM);
  assign clr  = (state == IDLE) || ((state == PAUSE) && stop);
  assign dp   = 1'b1;

`ifdef AUTO_REVERSE_EN
  logic eff_up;
  logic reach_top;
  logic reach_bot;

  // Never step outward from a boundary, so count cannot wrap even if started pointing out.
  always_comb begin
    eff_up = dir;
    if (count == '0 && !dir) eff_up = 1'b1;
    if (count == CNT_MAX && dir) eff_up = 1'b0;
  end

  assign reach_top = eff_up && (count == CNT_MAX - 1'b1);
  assign reach_bot = !eff_up && (count == WIDTH'(1));
  assign core_up   = eff_up;
  assign step_wrap = step && (reach_top || reach_bot);

  always_comb begin
    dir_nxt = dir;
    if (state == IDLE) begin
      if (go) dir_nxt = dir_sw;
    end else if (step) begin
      dir_nxt = reach_top ? 1'b0 : (reach_bot ? 1'b1 : eff_up);
    end
  end
`else
  assign core_up   = dir;
  assign step_wrap = step && (dir ? (count == CNT_MAX) : (count == '0));

  always_comb begin
    dir_nxt = dir;
    if (state == IDLE) begin
      if (go) dir_nxt = dir_sw;
    end else begin
      dir_nxt = dir_sw;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      dir   <= 1'b1;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      seg   <= SEG_UP;
    end else begin
      wrap <= 1'b0;
      dir  <= dir_nxt;
      seg  <= dir_nxt ? SEG_UP : SEG_DN;
      case (state)
        IDLE: begin
          if (go) begin
            state <= RUN;
            busy  <= 1'b1;
            presc <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= PAUSE;
            busy  <= 1'b0;
          end else begin
            presc <= (presc == PS_TERM) ? 8'd0 : presc + 8'd1;
            wrap  <= step_wrap;
          end
        end
        PAUSE: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            presc <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (step),
    .up    (core_up),
    .count (count)
  );

endmodule
